// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch PC generator.
// The state encoding is shared so the trace and debug tooling can decode it.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] PC_INC               = 32'd4;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC select: a redirect wins, then sequential advance, otherwise hold.
// Kept separate so a future branch predictor can share the same mux.
module fetch_next_pc
  import fetch_pkg::*;
(
  input  logic [31:0] cur_pc,
  input  logic [31:0] base_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        advance,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = cur_pc;
    if (redirect)
      next_pc = align_pc(redirect_pc);
    else if (advance)
      next_pc = base_pc + PC_INC;  // wraps modulo 2^32
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: owns the PC, issues single-outstanding word reads and
// presents {pc, instr} downstream; stale responses after a redirect are dropped.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_VECTOR = fetch_pkg::DEFAULT_RESET_VECTOR,
  parameter logic [31:0] NOP_INSTR    = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  import fetch_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         drop_q, drop_d;
  logic         if_valid_d;
  logic [31:0]  if_pc_d, if_instr_d;
  logic         advance;

  assign imem_req  = (state_q == REQ);
  assign imem_addr = pc_q;

  // A usable response moves the PC past the word just returned; any redirect,
  // in any state, overrides that inside the mux.
  assign advance = (state_q == WAIT) && imem_rvalid && !drop_q;

  fetch_next_pc u_next_pc (
    .cur_pc      (pc_q),
    .base_pc     (req_pc_q),
    .redirect    (redirect_valid),
    .redirect_pc (redirect_pc),
    .advance     (advance),
    .next_pc     (pc_d)
  );

  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    drop_d     = drop_q;
    if_valid_d = if_valid;
    if_pc_d    = if_pc;
    if_instr_d = if_instr;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_gnt) begin
          req_pc_d = pc_q;
          // A redirect in the grant cycle makes the granted access stale.
          drop_d   = redirect_valid;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (!drop_q && !redirect_valid) begin
            if_valid_d = 1'b1;
            if_pc_d    = req_pc_q;
            if_instr_d = imem_rdata;
            state_d    = HOLD;
          end else begin
            drop_d  = 1'b0;
            state_d = REQ;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid || if_ready) begin
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_VECTOR;
      req_pc_q <= RESET_VECTOR;
      drop_q   <= 1'b0;
      if_valid <= 1'b0;
      if_pc    <= RESET_VECTOR;
      if_instr <= NOP_INSTR;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
      if_valid <= if_valid_d;
      if_pc    <= if_pc_d;
      if_instr <= if_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: behavioural instruction memory, scoreboard of
// expected {pc, instr} deliveries, and one task per scenario.
module tb_fetch_pc_gen;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  fetch_pc_gen dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // memory model state
  bit          mem_manual = 1'b0;
  bit          pend = 1'b0;
  bit          use_ovr = 1'b0;
  int          lat = 0;
  int          pend_cnt = 0;
  int          gnt_stall = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] ovr_data = '0;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back(exp_t'{pc, mdata(pc)});
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Memory: grant when requested (after gnt_stall cycles), answer lat cycles
  // after the cycle following the grant. Drives at posedge+1, before tasks.
  initial begin
    forever begin
      @(negedge clk);
      if (!mem_manual && imem_req && imem_gnt) begin
        pend      = 1'b1;
        pend_cnt  = lat;
        pend_addr = imem_addr;
      end
      @(posedge clk);
      #1;
      if (!mem_manual) begin
        imem_rvalid = 1'b0;
        if (pend) begin
          if (pend_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = use_ovr ? ovr_data : mdata(pend_addr);
            use_ovr     = 1'b0;
            pend        = 1'b0;
          end else begin
            pend_cnt--;
          end
        end
        imem_gnt = 1'b0;
        if (imem_req) begin
          if (gnt_stall > 0) gnt_stall--;
          else imem_gnt = 1'b1;
        end
      end
    end
  end

  // Scoreboard: every accepted instruction must match the next expected one.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && if_valid && if_ready && !redirect_valid) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL deliver: got pc=%h instr=%h, expected nothing", if_pc, if_instr);
        end else begin
          mon_e = exp_q.pop_front();
          if (if_pc !== mon_e.pc || if_instr !== mon_e.instr) begin
            n_fail++;
            $display("FAIL deliver: got pc=%h instr=%h, expected pc=%h instr=%h",
                     if_pc, if_instr, mon_e.pc, mon_e.instr);
          end
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain: %0d deliveries missing, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20 && !if_valid; i++) tick();
    n_tests++;
    if (if_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s wait_valid: if_valid=%b, expected 1", name, if_valid);
    end
  endtask

  task automatic wait_grant(input string name);
    for (int i = 0; i < 20 && !(imem_req && imem_gnt); i++) tick();
    n_tests++;
    if (!(imem_req === 1'b1 && imem_gnt === 1'b1)) begin
      n_fail++;
      $display("FAIL %s wait_grant: req=%b gnt=%b, expected 1/1", name, imem_req, imem_gnt);
    end
  endtask

  task automatic test_reset;
    tick();
    n_tests++;
    if ({imem_req, imem_addr, if_valid, if_pc, if_instr} !== {1'b0, RV, 1'b0, RV, NOP}) begin
      n_fail++;
      $display("FAIL reset_values: req=%b addr=%h v=%b pc=%h instr=%h, expected 0/%h/0/%h/%h",
               imem_req, imem_addr, if_valid, if_pc, if_instr, RV, RV, NOP);
    end
  endtask

  task automatic test_zero_wait;
    rst = 1'b0;
    if_ready = 1'b1;
    push_exp(32'h0);
    push_exp(32'h4);
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_tests++;
      if (if_valid !== (c == 3)) begin
        n_fail++;
        $display("FAIL first_valid cycle %0d: if_valid=%b, expected %b", c, if_valid, c == 3);
      end
    end
    wait_drain("zero_wait");
    if_ready = 1'b0;
  endtask

  task automatic test_hold_stall;
    push_exp(32'h8);
    wait_valid("hold_stall");
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({if_valid, if_pc, if_instr, imem_req} !== {1'b1, 32'h8, mdata(32'h8), 1'b0}) begin
        n_fail++;
        $display("FAIL hold_stall cycle %0d: v=%b pc=%h instr=%h req=%b, expected 1/%h/%h/0",
                 i, if_valid, if_pc, if_instr, imem_req, 32'h8, mdata(32'h8));
      end
      tick();
    end
    push_exp(32'hC);
    if_ready = 1'b1;
    wait_drain("hold_stall");
    if_ready = 1'b0;
  endtask

  task automatic test_gnt_stall;
    wait_valid("gnt_stall");
    gnt_stall = 4;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0040;
    push_exp(32'h40);
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h40, 1'b0}) begin
        n_fail++;
        $display("FAIL gnt_stall cycle %0d: req=%b addr=%h v=%b, expected 1/%h/0",
                 i, imem_req, imem_addr, if_valid, 32'h40);
      end
      tick();
    end
    if_ready = 1'b1;
    wait_drain("gnt_stall");
    if_ready = 1'b0;
  endtask

  task automatic test_redirect_wait;
    wait_valid("redirect_wait");
    lat = 2;
    push_exp(32'h44);
    if_ready = 1'b1;
    wait_grant("redirect_wait");
    use_ovr  = 1'b1;
    ovr_data = 32'hDEAD_BEEF;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    push_exp(32'h100);
    tick();
    redirect_valid = 1'b0;
    lat = 0;
    wait_drain("redirect_wait");
    if_ready = 1'b0;
  endtask

  task automatic test_redirect_gnt_wrap;
    wait_valid("redirect_gnt");
    push_exp(32'h104);
    if_ready = 1'b1;
    wait_grant("redirect_gnt");
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    push_exp(32'hFFFF_FFFC);
    push_exp(32'h0000_0000);
    tick();
    redirect_valid = 1'b0;
    wait_drain("redirect_gnt");
    if_ready = 1'b0;
  endtask

  task automatic test_reset_midwait;
    wait_valid("reset_midwait");
    mem_manual  = 1'b1;
    pend        = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    push_exp(32'h4);
    if_ready = 1'b1;
    tick();
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
      n_fail++;
      $display("FAIL midwait_req: req=%b addr=%h, expected 1/%h", imem_req, imem_addr, 32'h8);
    end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({imem_req, imem_addr, if_valid, if_pc, if_instr} !== {1'b0, RV, 1'b0, RV, NOP}) begin
      n_fail++;
      $display("FAIL midwait_reset: req=%b addr=%h v=%b pc=%h instr=%h, expected 0/%h/0/%h/%h",
               imem_req, imem_addr, if_valid, if_pc, if_instr, RV, RV, NOP);
    end
    tick();
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    n_tests++;
    if ({imem_req, imem_addr, if_valid} !== {1'b1, RV, 1'b0}) begin
      n_fail++;
      $display("FAIL midwait_restart: req=%b addr=%h v=%b, expected 1/%h/0",
               imem_req, imem_addr, if_valid, RV);
    end
    push_exp(RV);
    mem_manual = 1'b0;
    wait_drain("reset_midwait");
    if_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_hold_stall();
    test_gnt_stall();
    test_redirect_wait();
    test_redirect_gnt_wrap();
    test_reset_midwait();
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
